// File: rtl/qos_ctrl_fsm_param_pkg.sv
// Purpose : shared types and FIFO-vector bit positions for the QoS control FSM.
// Latency : n/a (declarations only).
// Backpr. : n/a.
//
// Contents: qos_state_e state encoding, MF/VC/D bit-index helpers for the
// per-FIFO empty/error vectors, and the one-hot state-flag decode.
package qos_fsm_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } qos_state_e;

  // FIFO vectors are ordered MF first, then VCs, then Ds.
  localparam int MF_BIT      = 0;
  localparam int VC_BIT_BASE = 1;

  function automatic int vc_bit(input int vc);
    return VC_BIT_BASE + vc;
  endfunction

  function automatic int d_bit(input int num_vc, input int d);
    return VC_BIT_BASE + num_vc + d;
  endfunction

  // Flag order is {error, active, idle, init}; RESET maps to all zero.
  function automatic logic [3:0] state_flags(input qos_state_e s);
    logic [3:0] f;
    f = 4'b0000;
    case (s)
      ST_INIT:   f = 4'b0001;
      ST_IDLE:   f = 4'b0010;
      ST_ACTIVE: f = 4'b0100;
      ST_ERROR:  f = 4'b1000;
      default:   f = 4'b0000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/qos_ctrl_fsm_param_if.sv
// Purpose : bundles the configuration, FIFO status and status outputs of the QoS FSM.
// Latency : n/a (wires only).
// Backpr. : none; all signals are level/pulse status, no handshake.
//
// master : drives init, umbral_*_in, fifo_empties, fifo_errors; observes outputs.
// slave  : the FSM; observes config/status, drives umbral_*, state flags,
//          error_full and err_count.
interface qos_ctrl_fsm_param_if #(
  parameter int NUM_VC   = 2,
  parameter int NUM_D    = 2,
  parameter int MF_W     = 4,
  parameter int VC_W     = 16,
  parameter int D_W      = 4,
  parameter int ERRCNT_W = 8
);
  localparam int NUM_FIFO = 1 + NUM_VC + NUM_D;

  logic                    init;
  logic [MF_W-1:0]         umbral_mf_in;
  logic [NUM_VC*VC_W-1:0]  umbral_vc_in;
  logic [NUM_D*D_W-1:0]    umbral_d_in;
  logic [NUM_FIFO-1:0]     fifo_empties;
  logic [NUM_FIFO-1:0]     fifo_errors;

  logic [MF_W-1:0]         umbral_mf;
  logic [NUM_VC*VC_W-1:0]  umbral_vc;
  logic [NUM_D*D_W-1:0]    umbral_d;
  logic                    idle_out;
  logic                    active_out;
  logic                    init_out;
  logic                    error_out;
  logic [NUM_FIFO-1:0]     error_full;
  logic [ERRCNT_W-1:0]     err_count;

  modport master (
    output init, umbral_mf_in, umbral_vc_in, umbral_d_in, fifo_empties, fifo_errors,
    input  umbral_mf, umbral_vc, umbral_d, idle_out, active_out, init_out,
           error_out, error_full, err_count
  );

  modport slave (
    input  init, umbral_mf_in, umbral_vc_in, umbral_d_in, fifo_empties, fifo_errors,
    output umbral_mf, umbral_vc, umbral_d, idle_out, active_out, init_out,
           error_out, error_full, err_count
  );

endinterface

// File: rtl/qos_ctrl_fsm_param_debounce.sv
// Purpose : counts consecutive all-empty cycles while ACTIVE; flags when ACTIVE may drop to IDLE.
// Latency : hold_done is combinational on the IDLE_HOLD-th consecutive all-empty cycle.
// Backpr. : none.
//
// Ports: clk, reset (sync, active-high), enable (state is ACTIVE),
//        all_empty (every FIFO empty this cycle), hold_done (leave ACTIVE now).
module qos_idle_debounce #(
  parameter int IDLE_HOLD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic all_empty,
  output logic hold_done
);

  localparam int CW = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(IDLE_HOLD - 1);

  logic [CW-1:0] cnt_q;

  // cnt_q holds the number of all-empty cycles already seen, so the current
  // cycle completes the window when it equals IDLE_HOLD-1.
  assign hold_done = enable && all_empty && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!enable || !all_empty || hold_done) begin
      // Restart on any busy cycle, outside ACTIVE, and once the window fires
      // so a later ACTIVE period starts from zero.
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/qos_ctrl_fsm_param.sv
// Purpose : PCIe QoS TC/VC control FSM; latches FIFO thresholds in INIT, tracks IDLE/ACTIVE, sticky ERROR.
// Latency : all outputs registered; state flags/errors update on the edge that samples the cause,
//           thresholds appear one cycle after the INIT cycle that loaded them.
// Backpr. : none; inputs are sampled every cycle.
//
// Ports: clk, reset (sync, active-high, highest priority) and bus (slave modport):
//   config in : init, umbral_mf_in, umbral_vc_in, umbral_d_in
//   status in : fifo_empties, fifo_errors (bit 0 MF, then VCs, then Ds)
//   outputs   : umbral_mf/vc/d, idle/active/init/error_out, error_full, err_count
module qos_ctrl_fsm_param
  import qos_fsm_pkg::*;
#(
  parameter int NUM_VC    = 2,
  parameter int NUM_D     = 2,
  parameter int MF_W      = 4,
  parameter int VC_W      = 16,
  parameter int D_W       = 4,
  parameter int IDLE_HOLD = 2,
  parameter int ERRCNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  qos_ctrl_fsm_param_if.slave bus
);

  localparam int NUM_FIFO = 1 + NUM_VC + NUM_D;

  qos_state_e state_q, state_d;

  logic [MF_W-1:0]        umbral_mf_q;
  logic [NUM_VC*VC_W-1:0] umbral_vc_q;
  logic [NUM_D*D_W-1:0]   umbral_d_q;
  logic [3:0]             flags_q;
  logic [NUM_FIFO-1:0]    error_full_q;
  logic [ERRCNT_W-1:0]    err_count_q;

  logic all_empty;
  logic any_err;
  logic hold_done;

  assign all_empty = &bus.fifo_empties;
  assign any_err   = |bus.fifo_errors;

  qos_idle_debounce #(
    .IDLE_HOLD (IDLE_HOLD)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .enable    (state_q == ST_ACTIVE),
    .all_empty (all_empty),
    .hold_done (hold_done)
  );

  // Next state. Error beats init beats everything else; reset is applied in
  // the register process.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
      end
      ST_INIT: begin
        if (any_err)        state_d = ST_ERROR;
        else if (!bus.init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_err)         state_d = ST_ERROR;
        else if (bus.init)   state_d = ST_INIT;
        else if (!all_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // init is deliberately not looked at here: reconfiguration is only
        // allowed once traffic has drained back to IDLE.
        if (any_err)        state_d = ST_ERROR;
        else if (hold_done) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      flags_q      <= 4'b0000;
      umbral_mf_q  <= '0;
      umbral_vc_q  <= '0;
      umbral_d_q   <= '0;
      error_full_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q <= state_d;
      // Flags are registered from the next state so they line up with state_q.
      flags_q <= state_flags(state_d);

      if (state_q == ST_INIT) begin
        umbral_mf_q <= bus.umbral_mf_in;
        umbral_vc_q <= bus.umbral_vc_in;
        umbral_d_q  <= bus.umbral_d_in;
      end

      // Error capture keeps running in ERROR so late faults are still recorded.
      if (state_q != ST_RESET) begin
        error_full_q <= error_full_q | bus.fifo_errors;
        if (any_err && !(&err_count_q)) begin
          err_count_q <= err_count_q + 1'b1;
        end
      end
    end
  end

  assign bus.umbral_mf  = umbral_mf_q;
  assign bus.umbral_vc  = umbral_vc_q;
  assign bus.umbral_d   = umbral_d_q;
  assign bus.init_out   = flags_q[0];
  assign bus.idle_out   = flags_q[1];
  assign bus.active_out = flags_q[2];
  assign bus.error_out  = flags_q[3];
  assign bus.error_full = error_full_q;
  assign bus.err_count  = err_count_q;

endmodule
